// File: rtl/multi_channel_sequencer.sv
// multi_channel_sequencer
// Round-robin poller for NUM_CH converter channels sharing one sample bus.
// Each channel gets one-hot enable in RUN until its done flag arrives; the
// sample is latched and shown on four hex digits. A connect event parks the
// poller in CONN, where the reconfiguration controller is enabled until it
// reports completion.
//
// Build option: define SEQ_TIMEOUT_EN to add a per-channel RUN timeout that
// sets a sticky error flag and moves on. Without it RUN waits indefinitely
// and err_o is constant zero.
//
// Handshake note: done_i[ch_o] and cfg_done_i are sampled as single-cycle
// qualifiers. data_i is only looked at in the RUN cycle where done_i[ch_o]
// is high. Other done_i bits are ignored. conect_i is a level: every cycle
// it is high re-arms the connect-pending flag.
module multi_channel_sequencer #(
    parameter  int NUM_CH      = 4,
    parameter  int DATA_W      = 9,
    parameter  int TIMEOUT_CYC = 1023,
    localparam int CH_W        = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              conect_i,
    input  logic [NUM_CH-1:0] done_i,
    input  logic              cfg_done_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [NUM_CH-1:0] en_o,
    output logic              cfg_en_o,
    output logic [1:0]        state_o,
    output logic [CH_W-1:0]   ch_o,
    output logic [3:0]        conn_cnt_o,
    output logic [NUM_CH-1:0] err_o,
    output logic [3:0]        disp0_o,
    output logic [3:0]        disp1_o,
    output logic [3:0]        disp2_o,
    output logic [3:0]        disp3_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        CONN = 2'b10,
        NEXT = 2'b11
    } state_t;

    // Elaboration-time guard on the supported parameter ranges.
    if (NUM_CH < 2 || NUM_CH > 16 || DATA_W < 9 || DATA_W > 16 ||
        TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_param_check
        $error("multi_channel_sequencer: parameter out of range");
    end

    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

    state_t              state_q;
    state_t              state_nxt;
    logic [CH_W-1:0]     ch_q;
    logic [CH_W-1:0]     ch_nxt;
    logic [CH_W-1:0]     ch_inc;
    logic [CH_W-1:0]     last_ch_q;
    logic [DATA_W-1:0]   sample_q;
    logic [3:0]          conn_cnt_q;
    logic                pend_q;
    logic                armed_q;
    logic                capture;
    logic                timeout;
    logic                conn_done;
    logic [NUM_CH-1:0]   err_q;

    // Next channel index, wrapping at the last channel.
    assign ch_inc = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] tmo_cnt_q;
    logic        tmo_hit;
    assign tmo_hit = (tmo_cnt_q == TMO_LAST);
`else
    logic tmo_hit;
    assign tmo_hit = 1'b0;
`endif

    // State and channel registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
        end else begin
            state_q <= state_nxt;
            ch_q    <= ch_nxt;
        end
    end

    // Next-state logic plus the state-decoded enables.
    always_comb begin
        state_nxt = state_q;
        ch_nxt    = ch_q;
        capture   = 1'b0;
        timeout   = 1'b0;
        conn_done = 1'b0;
        en_o      = '0;
        cfg_en_o  = 1'b0;
        case (state_q)
            IDLE: begin
                // armed_q delays the first RUN by one edge after reset release
                ch_nxt = '0;
                if (armed_q) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                en_o = NUM_CH'(1) << ch_q;
                if (done_i[ch_q]) begin
                    // a completion on the timeout cycle still wins
                    capture   = 1'b1;
                    state_nxt = NEXT;
                end else if (tmo_hit) begin
                    timeout   = 1'b1;
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
                if (pend_q) begin
                    state_nxt = CONN;
                end else begin
                    state_nxt = RUN;
                    ch_nxt    = ch_inc;
                end
            end
            CONN: begin
                cfg_en_o = 1'b1;
                if (cfg_done_i) begin
                    conn_done = 1'b1;
                    state_nxt = RUN;
                    ch_nxt    = ch_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                ch_nxt    = '0;
            end
        endcase
    end

    // Datapath: sample/last-channel capture, connect bookkeeping, reset arm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q   <= '0;
            last_ch_q  <= '0;
            conn_cnt_q <= '0;
            pend_q     <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            if (capture) begin
                sample_q  <= data_i;
                last_ch_q <= ch_q;
            end else if (timeout) begin
                last_ch_q <= ch_q;
            end
            if (conn_done) begin
                conn_cnt_q <= conn_cnt_q + 4'd1;
            end
            // a new connect event overrides the clear from a finished CONN
            if (conect_i) begin
                pend_q <= 1'b1;
            end else if (conn_done) begin
                pend_q <= 1'b0;
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    // RUN cycle counter: counts while staying in RUN, zero otherwise so every
    // RUN entry starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if (state_q == RUN && state_nxt == RUN) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    // Sticky per-channel error flags: set on timeout, cleared on a good sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else if (capture) begin
            err_q[ch_q] <= 1'b0;
        end else if (timeout) begin
            err_q[ch_q] <= 1'b1;
        end
    end
`else
    assign err_q = '0;
`endif

    assign err_o      = err_q;
    assign state_o    = state_q;
    assign ch_o       = ch_q;
    assign conn_cnt_o = conn_cnt_q;

    // Hex display, decoded from registered state only.
    always_comb begin
        disp0_o = sample_q[3:0];
        disp1_o = sample_q[7:4];
        disp2_o = sample_q[DATA_W-1] ? 4'hA : 4'hC;
        disp3_o = 4'(last_ch_q);
        if (state_q == CONN) begin
            disp0_o = conn_cnt_q[0] ? 4'hE : 4'hB;
            disp1_o = conn_cnt_q[0] ? 4'hD : 4'hC;
            disp2_o = 4'hE;
            disp3_o = {2'b00, state_q};
        end else if (err_q[last_ch_q]) begin
            disp0_o = 4'hF;
            disp1_o = 4'hF;
        end
    end

endmodule

// File: tb/tb_multi_channel_sequencer.sv
// tb_multi_channel_sequencer
// Directed bench for multi_channel_sequencer. Instance "a" is 4 channels with
// an 8-cycle timeout (only active when SEQ_TIMEOUT_EN is defined), instance
// "b" is 3 channels for the wrap and foreign-done cases.
module tb_multi_channel_sequencer;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_CONN = 2'b10;
    localparam logic [1:0] S_NEXT = 2'b11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic rst_b;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $error("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus signals ----------------
    logic       conect;
    logic       cfg_done;
    logic [8:0] data;
    logic [3:0] a_done;
    logic [2:0] b_done;

    logic [3:0] a_en, a_err, a_cnt, a_d0, a_d1, a_d2, a_d3;
    logic       a_cfg_en;
    logic [1:0] a_st, a_ch;
    logic [2:0] b_en, b_err;
    logic [3:0] b_cnt, b_d0, b_d1, b_d2, b_d3;
    logic       b_cfg_en;
    logic [1:0] b_st, b_ch;

    multi_channel_sequencer #(.NUM_CH(4), .DATA_W(9), .TIMEOUT_CYC(8)) dut_a (
        .clk(clk), .rst(rst), .conect_i(conect), .done_i(a_done),
        .cfg_done_i(cfg_done), .data_i(data), .en_o(a_en), .cfg_en_o(a_cfg_en),
        .state_o(a_st), .ch_o(a_ch), .conn_cnt_o(a_cnt), .err_o(a_err),
        .disp0_o(a_d0), .disp1_o(a_d1), .disp2_o(a_d2), .disp3_o(a_d3)
    );

    multi_channel_sequencer #(.NUM_CH(3), .DATA_W(9), .TIMEOUT_CYC(1023)) dut_b (
        .clk(clk), .rst(rst_b), .conect_i(1'b0), .done_i(b_done),
        .cfg_done_i(1'b0), .data_i(data), .en_o(b_en), .cfg_en_o(b_cfg_en),
        .state_o(b_st), .ch_o(b_ch), .conn_cnt_o(b_cnt), .err_o(b_err),
        .disp0_o(b_d0), .disp1_o(b_d1), .disp2_o(b_d2), .disp3_o(b_d3)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [12:0] exp_q[$];   // {last_ch[3:0], sample[8:0]}
    logic [8:0]  last_sample;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected digits {d3,d2,d1,d0} for a non-CONN state.
    function automatic logic [15:0] disp_model(input logic [8:0] s, input logic [3:0] lch,
                                               input logic e);
        logic [3:0] d0, d1, d2;
        d0 = e ? 4'hF : s[3:0];
        d1 = e ? 4'hF : s[7:4];
        d2 = s[8] ? 4'hA : 4'hC;
        return {lch, d2, d1, d0};
    endfunction

    task automatic sb_pop(input string tag, input logic [15:0] obs_disp);
        logic [12:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs_disp, disp_model(e[8:0], e[12:9], 1'b0));
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge while instance a is in RUN on channel c; returns at
    // the negedge after the NEXT cycle.
    task automatic serve_a(input int c, input logic [8:0] d);
        check("a_run_en", a_en, 32'(1 << c));
        check("a_run_ch", a_ch, c);
        a_done = 4'(1 << c);
        data   = d;
        exp_q.push_back({4'(c), d});
        last_sample = d;
        @(negedge clk);
        a_done = '0;
        check("a_next_state", a_st, S_NEXT);
        check("a_next_en", a_en, 0);
        sb_pop("a_disp", {a_d3, a_d2, a_d1, a_d0});
        @(negedge clk);
    endtask

    function automatic logic [8:0] rnd9();
        return 9'($urandom_range(0, 511));
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; rst_b = 1'b1;
        conect = 1'b0; cfg_done = 1'b0; data = '0;
        a_done = '0; b_done = '0; last_sample = '0;
        repeat (2) @(negedge clk);

        // reset state
        check("rst_state", a_st, S_IDLE);
        check("rst_ch", a_ch, 0);
        check("rst_en", a_en, 0);
        check("rst_cfg_en", a_cfg_en, 0);
        check("rst_cnt", a_cnt, 0);
        check("rst_err", a_err, 0);
        check("rst_disp", {a_d3, a_d2, a_d1, a_d0}, 16'h0C00);

        // release: RUN begins on the second edge
        rst = 1'b0;
        @(negedge clk);
        check("rel_idle", a_st, S_IDLE);
        @(negedge clk);
        check("rel_run", a_st, S_RUN);

        // round-robin with 1A5 on every channel
        for (int c = 0; c < 4; c++) serve_a(c, 9'h1A5);
        check("wrap_en", a_en, 4'b0001);
        check("disp0_5", a_d0, 4'h5);
        check("disp1_A", a_d1, 4'hA);
        check("disp2_A", a_d2, 4'hA);
        check("disp3_3", a_d3, 4'h3);
        serve_a(0, rnd9());

        // connect pulse during RUN ch1
        conect = 1'b1;
        @(negedge clk);
        conect = 1'b0;
        check("pend_run_state", a_st, S_RUN);
        serve_a(1, rnd9());
        check("conn_state", a_st, S_CONN);
        check("conn_cfg_en", a_cfg_en, 1);
        check("conn_en", a_en, 0);
        check("conn_disp_cnt0", {a_d3, a_d2, a_d1, a_d0}, 16'h2ECB);
        cfg_done = 1'b1;
        @(negedge clk);
        cfg_done = 1'b0;
        check("post_conn_state", a_st, S_RUN);
        check("post_conn_ch", a_ch, 2);
        check("post_conn_cnt", a_cnt, 1);
        check("post_conn_cfg_en", a_cfg_en, 0);

        // CONN at count 1, then connect and cfg_done together
        conect = 1'b1;
        @(negedge clk);
        conect = 1'b0;
        serve_a(2, rnd9());
        check("conn1_state", a_st, S_CONN);
        check("conn1_disp", {a_d3, a_d2, a_d1, a_d0}, 16'h2EDE);
        conect = 1'b1; cfg_done = 1'b1;
        @(negedge clk);
        conect = 1'b0; cfg_done = 1'b0;
        check("same_cyc_state", a_st, S_RUN);
        check("same_cyc_ch", a_ch, 3);
        check("same_cyc_cnt", a_cnt, 2);
        serve_a(3, rnd9());
        check("conn2_state", a_st, S_CONN);
        check("conn2_disp", {a_d3, a_d2, a_d1, a_d0}, 16'h2ECB);

        // reset while in CONN
        check("pre_rst_cfg_en", a_cfg_en, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_en", a_en, 0);
        check("mid_rst_cfg_en", a_cfg_en, 0);
        check("mid_rst_state", a_st, S_IDLE);
        check("mid_rst_ch", a_ch, 0);
        check("mid_rst_cnt", a_cnt, 0);
        check("mid_rst_err", a_err, 0);
        check("mid_rst_disp", {a_d3, a_d2, a_d1, a_d0}, 16'h0C00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rerun_state", a_st, S_RUN);
        serve_a(0, rnd9());
        check("pend_dropped", a_st, S_RUN);
        serve_a(1, rnd9());

`ifdef SEQ_TIMEOUT_EN
        // channel 2 silent for the full timeout window
        for (int i = 0; i < 8; i++) begin
            check("tmo_wait_state", a_st, S_RUN);
            @(negedge clk);
        end
        check("tmo_next", a_st, S_NEXT);
        check("tmo_err", a_err, 4'b0100);
        check("tmo_disp01", {a_d1, a_d0}, 8'hFF);
        check("tmo_disp3", a_d3, 4'h2);
        check("tmo_disp", {a_d3, a_d2, a_d1, a_d0}, disp_model(last_sample, 4'd2, 1'b1));
        @(negedge clk);
        check("tmo_run_ch3", a_ch, 3);
        check("tmo_run_state", a_st, S_RUN);
        serve_a(3, rnd9());
        serve_a(0, rnd9());
        serve_a(1, rnd9());
        check("tmo_sticky", a_err, 4'b0100);
        // done on the final cycle of the window beats the timeout
        for (int i = 0; i < 7; i++) begin
            check("late_wait_state", a_st, S_RUN);
            @(negedge clk);
        end
        data   = rnd9();
        a_done = 4'b0100;
        exp_q.push_back({4'd2, data});
        @(negedge clk);
        a_done = '0;
        check("late_next", a_st, S_NEXT);
        check("late_err", a_err, 0);
        sb_pop("late_disp", {a_d3, a_d2, a_d1, a_d0});
`else
        // without the timeout option RUN just waits
        for (int i = 0; i < 20; i++) @(negedge clk);
        check("wait_state", a_st, S_RUN);
        check("wait_ch", a_ch, 2);
        check("wait_err", a_err, 0);
        serve_a(2, rnd9());
`endif

        // 3-channel instance: foreign done ignored, wrap 2 -> 0
        rst_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("b_run", b_st, S_RUN);
        b_done = 3'b010;
        repeat (2) @(negedge clk);
        b_done = '0;
        check("b_ignore_state", b_st, S_RUN);
        check("b_ignore_ch", b_ch, 0);
        check("b_ignore_en", b_en, 3'b001);
        for (int c = 0; c < 3; c++) begin
            check("b_run_ch", b_ch, c);
            check("b_run_en", b_en, 32'(1 << c));
            data   = rnd9();
            b_done = 3'(1 << c);
            exp_q.push_back({4'(c), data});
            @(negedge clk);
            b_done = '0;
            check("b_next", b_st, S_NEXT);
            sb_pop("b_disp", {b_d3, b_d2, b_d1, b_d0});
            @(negedge clk);
        end
        check("b_wrap_ch", b_ch, 0);
        check("b_wrap_state", b_st, S_RUN);
        check("b_err", b_err, 0);
        check("b_cnt", b_cnt, 0);
        check("b_cfg_en", b_cfg_en, 0);
        check("sb_drained", exp_q.size(), 0);

        // ---------------- final report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multi_channel_sequencer.md
MULTI_CHANNEL_SEQUENCER -- requirements
Module: multi_channel_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of converter channels polled round-robin (legal range 2..16).
REQ-002 The block SHALL have parameter DATA_W, default 9, meaning the width of the shared sample bus (legal range 9..16).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 1023, meaning the number of RUN cycles allowed before a channel is declared failed (legal range 1..65535).
REQ-004 The block SHALL have local parameter CH_W = max(1, clog2(NUM_CH)).
REQ-005 The block SHALL have port clk, input, 1, system clock; all state changes occur on the rising edge.
REQ-006 The block SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-007 The block SHALL have port conect_i, input, 1, device connect/disconnect event (a pulse or a level; a level is treated as repeated events).
REQ-008 The block SHALL have port done_i, input, NUM_CH, per-channel conversion-complete flags.
REQ-009 The block SHALL have port cfg_done_i, input, 1, reconfiguration-complete flag.
REQ-010 The block SHALL have port data_i, input, DATA_W, shared sample bus; it is valid in the cycle that done_i[ch_o] is high.
REQ-011 The block SHALL have port en_o, output, NUM_CH, one-hot channel enable.
REQ-012 The block SHALL have port cfg_en_o, output, 1, reconfiguration controller enable.
REQ-013 The block SHALL have port state_o, output, 2, current state encoding.
REQ-014 The block SHALL have port ch_o, output, CH_W, index of the current channel.
REQ-015 The block SHALL have port conn_cnt_o, output, 4, count of serviced connect events, wrapping modulo 16.
REQ-016 The block SHALL have port err_o, output, NUM_CH, sticky per-channel timeout flags.
REQ-017 The block SHALL have ports disp0_o, disp1_o, disp2_o and disp3_o, each output, 4, hex digit codes for display digits 0 to 3.

Function
REQ-018 The state machine SHALL use the encoding IDLE=2'b00, RUN=2'b01, CONN=2'b10, NEXT=2'b11, and state_o SHALL equal the state register.
REQ-019 IDLE SHALL go to RUN after one cycle with ch_o=0.
REQ-020 In RUN, en_o SHALL equal 1<<ch_o; in every other state en_o SHALL be all zeros.
REQ-021 In RUN, when done_i[ch_o]=1 the block SHALL capture data_i into the sample register, capture ch_o into the last-channel register, clear err_o[ch_o], and go to NEXT on the following edge.
REQ-022 In RUN, done_i bits other than done_i[ch_o] SHALL be ignored.
REQ-023 NEXT SHALL go to CONN if the connect-pending flag is set; otherwise it SHALL go to RUN with ch_o = (ch_o+1) wrapping from NUM_CH-1 to 0.
REQ-024 In CONN, cfg_en_o SHALL be 1; in every other state cfg_en_o SHALL be 0.
REQ-025 In CONN, when cfg_done_i=1 the block SHALL clear the pending flag, increment conn_cnt_o, and go to RUN with ch_o advanced as defined in REQ-023.
REQ-026 The connect-pending flag SHALL be set in any state by conect_i=1.
REQ-027 When conect_i=1 and the pending-flag clear of REQ-025 occur in the same cycle, the set SHALL win: the flag stays set and conn_cnt_o still increments.
REQ-028 Display in IDLE, RUN and NEXT: disp0_o SHALL be sample[3:0], disp1_o SHALL be sample[7:4], disp2_o SHALL be 4'hA if sample[DATA_W-1]=1 else 4'hC, and disp3_o SHALL be the zero-extended last-channel register.
REQ-029 The display in IDLE, RUN and NEXT SHALL override REQ-028 when err_o is set for the last-channel register: disp0_o and disp1_o SHALL be 4'hF.
REQ-030 Display in CONN: disp0_o SHALL be 4'hE if conn_cnt_o[0]=1 else 4'hB, disp1_o SHALL be 4'hD if conn_cnt_o[0]=1 else 4'hC, disp2_o SHALL be 4'hE, and disp3_o SHALL be {2'b00, state_o}.
REQ-031 All display outputs SHALL be combinational from registered state only.

Reset
REQ-032 While rst=1, asynchronously: state SHALL be IDLE, ch_o=0, en_o=0, cfg_en_o=0, conn_cnt_o=0, err_o=0, pending flag=0, sample register=0, last-channel register=0, and the timeout counter=0.
REQ-033 Reset asserted mid-RUN or mid-CONN SHALL drop en_o and cfg_en_o in the same cycle and SHALL discard any pending event.
REQ-034 The first RUN after reset release SHALL begin 2 edges after release.

Configuration
REQ-035 Macro SEQ_TIMEOUT_EN defined: a 16-bit counter SHALL clear on RUN entry and increment every RUN cycle.
REQ-036 Macro SEQ_TIMEOUT_EN defined: when the counter reaches TIMEOUT_CYC-1 without done_i[ch_o], the block SHALL set err_o[ch_o], capture ch_o into the last-channel register, leave the sample register unchanged, and go to NEXT.
REQ-037 Macro SEQ_TIMEOUT_EN defined: done_i[ch_o] arriving on the timeout cycle SHALL take priority (normal capture, no error).
REQ-038 Macro SEQ_TIMEOUT_EN undefined: RUN SHALL wait indefinitely, err_o SHALL be tied to 0, and no counter SHALL be synthesised.

Verification
REQ-039 The bench SHALL cover: reset, then done_i pulsed for each channel with data_i=9'h1A5 -> en_o sequence 0001,0010,0100,1000,0001; disp0_o=5, disp1_o=A, disp2_o=A.
REQ-040 The bench SHALL cover: conect_i pulse during RUN ch1, then done_i[1] -> NEXT, then CONN with cfg_en_o=1; after cfg_done_i -> conn_cnt_o=1, RUN ch2, and CONN display E,D,E.
REQ-041 The bench SHALL cover: conect_i and cfg_done_i in the same cycle -> conn_cnt_o increments, the block re-enters CONN at the next NEXT, and CONN display B,C,E at conn_cnt_o=2.
REQ-042 The bench SHALL cover, with SEQ_TIMEOUT_EN and TIMEOUT_CYC=8: channel 2 never asserts done_i -> after 8 RUN cycles err_o=0100, disp0_o=disp1_o=F, disp3_o=2, and the next RUN is on ch3.
REQ-043 The bench SHALL cover, with SEQ_TIMEOUT_EN and TIMEOUT_CYC=8: done_i[2] on the 8th cycle -> no error and the sample is captured.
REQ-044 The bench SHALL cover: rst asserted while in CONN -> en_o=0 and cfg_en_o=0 immediately, and all outputs at reset values.
REQ-045 The bench SHALL cover: NUM_CH=3 -> ch_o wraps 2 to 0, and done_i[1] asserted while ch_o=0 is ignored.
